// File: rtl/sparc_rf_pkg.sv
// Shared definitions for the integer register bank (write port and read muxes).
package sparc_rf_pkg;

    localparam int unsigned ADDR_BITS  = 5;
    localparam int unsigned NUM_REGS   = 1 << ADDR_BITS;
    localparam int unsigned DATA_WIDTH = 32;

    typedef enum logic {
        IDLE,
        CLEAR
    } rf_state_e;

    localparam logic [DATA_WIDTH-1:0] REG_ZERO = '0;

endpackage

// File: rtl/rf_addr_decoder.sv
// Binary register index to one-hot write enable, gated by a single enable.
module rf_addr_decoder
    import sparc_rf_pkg::*;
#(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned N_REGS = 32
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              en_i,
    output logic [N_REGS-1:0] onehot_o
);

    // At most one bit set, and only when enabled
    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[addr_i] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_write_port.sv
// Write side of the 32-entry register bank: storage, write handshake, sequenced bulk clear.
module regfile_write_port
    import sparc_rf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = sparc_rf_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_BITS  = sparc_rf_pkg::ADDR_BITS,
    parameter int unsigned ZERO_R0    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_BITS-1:0]  wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  clr_req,
    output logic                  clr_busy,
    output logic [DATA_WIDTH-1:0] r0,  r1,  r2,  r3,  r4,  r5,  r6,  r7,
    output logic [DATA_WIDTH-1:0] r8,  r9,  r10, r11, r12, r13, r14, r15,
    output logic [DATA_WIDTH-1:0] r16, r17, r18, r19, r20, r21, r22, r23,
    output logic [DATA_WIDTH-1:0] r24, r25, r26, r27, r28, r29, r30, r31
);

    localparam int unsigned NREGS = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] LAST_IDX = ADDR_BITS'(NREGS - 1);
    localparam logic [ADDR_BITS-1:0] FIRST_CLR = (ZERO_R0 != 0) ? ADDR_BITS'(1) : '0;

    rf_state_e              state_q, state_d;
    logic [ADDR_BITS-1:0]   cnt_q, cnt_d;
    logic                   fire;
    logic [ADDR_BITS-1:0]   dec_addr;
    logic                   dec_en;
    logic [NREGS-1:0]       we;
    logic [DATA_WIDTH-1:0]  wdata;
    logic [DATA_WIDTH-1:0]  regs [NREGS];

    // Status decoded purely from registered state
    always_comb begin
        clr_busy = (state_q == CLEAR);
        wr_ready = ~clr_busy;
        fire     = wr_valid & wr_ready;
        // During a clear the counter steers the shared decoder and data is forced to zero
        dec_addr = clr_busy ? cnt_q : wr_addr;
        dec_en   = fire | clr_busy;
        wdata    = clr_busy ? DATA_WIDTH'(REG_ZERO) : wr_data;
    end

    // Next-state and clear counter sequencing
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = FIRST_CLR;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + ADDR_BITS'(1);
                if (cnt_q == LAST_IDX) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM state and clear counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    rf_addr_decoder #(
        .ADDR_W (ADDR_BITS),
        .N_REGS (NREGS)
    ) u_dec (
        .addr_i   (dec_addr),
        .en_i     (dec_en),
        .onehot_o (we)
    );

    for (genvar i = 0; i < NREGS; i++) begin : g_reg
        if (i == 0 && ZERO_R0 != 0) begin : g_zero
            // Writes to r0 complete the handshake but have nowhere to land
            logic unused_we;
            assign unused_we = we[i];
            assign regs[i]   = '0;
        end else begin : g_flop
            logic [DATA_WIDTH-1:0] reg_d, reg_q;

            // Load on this register's enable, otherwise hold
            always_comb begin
                reg_d = reg_q;
                if (we[i]) begin
                    reg_d = wdata;
                end
            end

            // Storage flop
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    reg_q <= '0;
                end else begin
                    reg_q <= reg_d;
                end
            end

            assign regs[i] = reg_q;
        end
    end

    assign r0  = regs[0];  assign r1  = regs[1];  assign r2  = regs[2];  assign r3  = regs[3];
    assign r4  = regs[4];  assign r5  = regs[5];  assign r6  = regs[6];  assign r7  = regs[7];
    assign r8  = regs[8];  assign r9  = regs[9];  assign r10 = regs[10]; assign r11 = regs[11];
    assign r12 = regs[12]; assign r13 = regs[13]; assign r14 = regs[14]; assign r15 = regs[15];
    assign r16 = regs[16]; assign r17 = regs[17]; assign r18 = regs[18]; assign r19 = regs[19];
    assign r20 = regs[20]; assign r21 = regs[21]; assign r22 = regs[22]; assign r23 = regs[23];
    assign r24 = regs[24]; assign r25 = regs[25]; assign r26 = regs[26]; assign r27 = regs[27];
    assign r28 = regs[28]; assign r29 = regs[29]; assign r30 = regs[30]; assign r31 = regs[31];

endmodule
